// File: rtl/vpu_ub_writeback_if.sv
// Unified-buffer write port bundle between the VPU writeback stage and the UB.
//
// Handshake: the master raises ub_wr_en with a stable ub_wr_addr/ub_wr_data
// and holds all three unchanged until a cycle in which ub_wr_ready is also
// high; that cycle transfers exactly one word. ready may toggle freely and
// has no effect while ub_wr_en is low.
//
// Signals:
//   ub_wr_en     master -> slave  write request
//   ub_wr_addr   master -> slave  ADDR_WIDTH word address
//   ub_wr_data   master -> slave  2*DATA_WIDTH row word {lane2,lane1}
//   ub_wr_ready  slave  -> master slave accepts a word this cycle
interface vpu_ub_writeback_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                    ub_wr_en;
    logic [ADDR_WIDTH-1:0]   ub_wr_addr;
    logic [2*DATA_WIDTH-1:0] ub_wr_data;
    logic                    ub_wr_ready;

    modport master (
        output ub_wr_en,
        output ub_wr_addr,
        output ub_wr_data,
        input  ub_wr_ready
    );

    modport slave (
        input  ub_wr_en,
        input  ub_wr_addr,
        input  ub_wr_data,
        output ub_wr_ready
    );
endinterface

// File: rtl/vpu_ub_writeback.sv
// VPU -> unified-buffer writeback stage.
//
// Takes the two skewed VPU output lanes (lane 2 trails lane 1 by one cycle),
// re-aligns them into row words {lane2,lane1}, buffers the rows in a small
// FIFO and writes them to consecutive unified-buffer addresses starting at
// base_addr. done pulses for one cycle after the final row is accepted.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   start                  launch pulse, honoured only when idle
//   base_addr, num_rows    job description, latched on start
//   two_col                1: pair both lanes; 0: lane 1 only, upper half 0
//   vpu_data_in_1/2        lane data
//   vpu_valid_in_1/2       lane valids (ignored unless collecting)
//   ub                     UB write port (master side, valid/ready)
//   busy                   job in progress (COLLECT or DRAIN)
//   done                   one-cycle completion pulse
//   overflow               sticky: a row arrived while the FIFO was full
//   dbg_state              current FSM state encoding
//   skew_err               only when WB_SKEW_CHECK_EN is defined: sticky lane
//                          skew error (orphan lane 2 or unpaired lane 1)
//
// Configuration macro: WB_SKEW_CHECK_EN adds the skew_err output.
// FIFO_DEPTH must be a power of two and at least 2.
module vpu_ub_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ROWS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ROWS_WIDTH-1:0] num_rows,
    input  logic                  two_col,
    input  logic [DATA_WIDTH-1:0] vpu_data_in_1,
    input  logic [DATA_WIDTH-1:0] vpu_data_in_2,
    input  logic                  vpu_valid_in_1,
    input  logic                  vpu_valid_in_2,
    vpu_ub_writeback_if.master    ub,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            dbg_state
`ifdef WB_SKEW_CHECK_EN
    ,
    output logic                  skew_err
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ROWS_WIDTH-1:0] num_rows_q;
    logic [ROWS_WIDTH-1:0] rows_enq_q;
    logic [ROWS_WIDTH-1:0] rows_wr_q;

    logic                  pend_v_q, pend_v_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;

    logic [WORD_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    logic              enq_fire;
    logic [WORD_W-1:0] enq_word;
    logic              enq_ok;
    logic              enq_drop;
    logic              fifo_full;
    logic              wr_en;
    logic              deq;
    logic              launch;
    logic              done_d;
    logic              done_q;
    logic              overflow_q;

    assign fifo_full = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign wr_en     = (fifo_cnt_q != '0);
    assign deq       = wr_en && ub.ub_wr_ready;
    // A same-cycle dequeue frees the slot the incoming row needs.
    assign enq_ok    = enq_fire && (!fifo_full || deq);
    assign enq_drop  = enq_fire && fifo_full && !deq;

    // Deskew: lane 1 parks in pend_data until its lane-2 partner arrives.
    // When both valids coincide, lane 2 closes the OLD pending row and the
    // new lane 1 immediately becomes the next pending element.
    always_comb begin
        enq_fire    = 1'b0;
        enq_word    = '0;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        if (state_q == S_COLLECT) begin
            if (two_col) begin
                if (vpu_valid_in_2 && pend_v_q) begin
                    enq_fire = 1'b1;
                    enq_word = {vpu_data_in_2, pend_data_q};
                    pend_v_d = 1'b0;
                end
                if (vpu_valid_in_1) begin
                    pend_data_d = vpu_data_in_1;
                    pend_v_d    = 1'b1;
                end
            end else if (vpu_valid_in_1) begin
                enq_fire = 1'b1;
                enq_word = {{DATA_WIDTH{1'b0}}, vpu_data_in_1};
            end
        end
    end

    // Dropped rows still count as enqueued, so the drain phase ends when the
    // FIFO runs empty rather than when rows_wr reaches num_rows; without
    // drops the two conditions coincide.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    launch = 1'b1;
                    if (num_rows == '0) done_d  = 1'b1;
                    else                state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Leave on the edge of the last enqueue so no extra row slips in.
                if (enq_fire && (rows_enq_q + ROWS_WIDTH'(1) == num_rows_q))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!wr_en || (deq && fifo_cnt_q == CNT_W'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            num_rows_q  <= '0;
            rows_enq_q  <= '0;
            rows_wr_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done_d;
            if (launch) begin
                base_q      <= base_addr;
                num_rows_q  <= num_rows;
                rows_enq_q  <= '0;
                rows_wr_q   <= '0;
                pend_v_q    <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                pend_v_q    <= pend_v_d;
                pend_data_q <= pend_data_d;
                if (enq_fire) rows_enq_q <= rows_enq_q + ROWS_WIDTH'(1);
                if (deq)      rows_wr_q  <= rows_wr_q + ROWS_WIDTH'(1);
                if (enq_drop) overflow_q <= 1'b1;
            end
        end
    end

    // FIFO bookkeeping. Storage itself needs no reset: the output is masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (enq_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (deq)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(enq_ok) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok) mem[wr_ptr_q] <= enq_word;
    end

`ifdef WB_SKEW_CHECK_EN
    logic skew_evt;
    logic skew_err_q;

    // Orphan lane 2, or a fresh lane 1 overwriting an unpaired pending lane 1.
    assign skew_evt = (state_q == S_COLLECT) && two_col &&
                      ((vpu_valid_in_2 && !pend_v_q) ||
                       (vpu_valid_in_1 && pend_v_q && !vpu_valid_in_2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          skew_err_q <= 1'b0;
        else if (launch)   skew_err_q <= 1'b0;
        else if (skew_evt) skew_err_q <= 1'b1;
    end

    assign skew_err = skew_err_q;
`endif

    // Address wraps modulo 2^ADDR_WIDTH by construction of the adder width.
    assign ub.ub_wr_en   = wr_en;
    assign ub.ub_wr_addr = wr_en ? (base_q + ADDR_WIDTH'(rows_wr_q)) : '0;
    assign ub.ub_wr_data = wr_en ? mem[rd_ptr_q] : '0;

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule
